// File: rtl/egress_rd_req_gen.sv
// Memory Read request generator: arbitrates three read clients, allocates a PCIe tag,
// emits a single-beat MRd TLP header and publishes {dst, tag} for completion routing.
module egress_rd_req_gen #(
  parameter int unsigned TAG_W           = 5,
  parameter int unsigned DST_W           = 2,
  parameter int unsigned T_W             = TAG_W + DST_W,
  parameter logic [15:0] REQ_ID          = 16'h0000,
  parameter int unsigned PCIE_DATA_WIDTH = 128,
  parameter int unsigned PCIE_DATA_KW    = PCIE_DATA_WIDTH / 32,
  parameter int unsigned PCIE_TUSER_W    = 22
) (
  input  logic                       clk,
  input  logic                       rst_n,

  input  logic [63:0]                s_rxsgl_addr,
  input  logic [9:0]                 s_rxsgl_len,
  input  logic                       s_rxsgl_valid,
  output logic                       s_rxsgl_rdy,

  input  logic [63:0]                s_txsgl_addr,
  input  logic [9:0]                 s_txsgl_len,
  input  logic                       s_txsgl_valid,
  output logic                       s_txsgl_rdy,

  input  logic [63:0]                s_rxdat_addr,
  input  logic [9:0]                 s_rxdat_len,
  input  logic                       s_rxdat_valid,
  output logic                       s_rxdat_rdy,

  input  logic                       m_axis_rx_tready,
  output logic [PCIE_DATA_WIDTH-1:0] m_axis_rx_tdata,
  output logic [PCIE_DATA_KW-1:0]    m_axis_rx_tkeep,
  output logic                       m_axis_rx_sop,
  output logic                       m_axis_rx_eop,
  output logic                       m_axis_rx_tvalid,
  output logic [PCIE_TUSER_W-1:0]    m_axis_rx_tuser,

  output logic [T_W-1:0]             tag,
  output logic                       tag_vld,
  input  logic [TAG_W-1:0]           tag_free,
  input  logic                       tag_free_vld,
  output logic [TAG_W:0]             outstanding,
  output logic                       err_dbl_free
);

  localparam int unsigned NumTags = 1 << TAG_W;

  localparam logic [DST_W-1:0] DstRxSgl = DST_W'(0);
  localparam logic [DST_W-1:0] DstTxSgl = DST_W'(1);
  localparam logic [DST_W-1:0] DstRxDat = DST_W'(3);

  typedef enum logic {StIdle, StSend} state_e;

  state_e                     state_q;
  logic [1:0]                 rr_q;
  logic [PCIE_DATA_WIDTH-1:0] tdata_q;
  logic [PCIE_DATA_KW-1:0]    tkeep_q;
  logic [T_W-1:0]             tag_q;
  logic [NumTags-1:0]         free_q, free_d;
  logic [TAG_W:0]             outstanding_q, outstanding_d;
  logic                       err_q;

  logic [3:0]                 req_vld;
  logic [1:0]                 ord0, ord1, ord2;
  logic                       gnt_any;
  logic [1:0]                 gnt_idx;
  logic [1:0]                 rr_next;
  logic                       pool_avail;
  logic [TAG_W-1:0]           alloc_tag;
  logic                       accept;
  logic                       handshake;
  logic                       rel_ok;
  logic                       rel_dbl;

  logic [63:0]                sel_addr;
  logic [9:0]                 sel_len;
  logic [DST_W-1:0]           sel_dst;
  logic                       is_4dw;
  logic [31:0]                dw0, dw1, dw2, dw3;
  logic [PCIE_DATA_WIDTH-1:0] hdr_data;
  logic [PCIE_DATA_KW-1:0]    hdr_keep;

  // Round-robin: search starts at rr_q and wraps in rx SGL -> tx SGL -> rx data order.
  always_comb begin
    req_vld = {1'b0, s_rxdat_valid, s_txsgl_valid, s_rxsgl_valid};
    unique case (rr_q)
      2'd1:    begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd2:    begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
    endcase
    gnt_any = 1'b1;
    if (req_vld[ord0])      gnt_idx = ord0;
    else if (req_vld[ord1]) gnt_idx = ord1;
    else if (req_vld[ord2]) gnt_idx = ord2;
    else begin
      gnt_idx = 2'd0;
      gnt_any = 1'b0;
    end
    rr_next = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
  end

  always_comb begin
    alloc_tag = '0;
    for (int i = NumTags - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_tag = TAG_W'(i);
    end
  end

  assign pool_avail = |free_q;
  assign accept     = (state_q == StIdle) && gnt_any && pool_avail;
  assign handshake  = (state_q == StSend) && m_axis_rx_tready;

  assign s_rxsgl_rdy = accept && (gnt_idx == 2'd0);
  assign s_txsgl_rdy = accept && (gnt_idx == 2'd1);
  assign s_rxdat_rdy = accept && (gnt_idx == 2'd2);

  always_comb begin
    unique case (gnt_idx)
      2'd0: begin sel_addr = s_rxsgl_addr; sel_len = s_rxsgl_len; sel_dst = DstRxSgl; end
      2'd1: begin sel_addr = s_txsgl_addr; sel_len = s_txsgl_len; sel_dst = DstTxSgl; end
      default: begin
        sel_addr = s_rxdat_addr;
        sel_len  = s_rxdat_len;
        sel_dst  = DstRxDat;
      end
    endcase
  end

  // MRd header; fmt/type/TC/attr/TD/EP all zero apart from the 4DW fmt bit.
  always_comb begin
    is_4dw = |sel_addr[63:32];
    dw0    = {is_4dw ? 3'b001 : 3'b000, 5'b00000, 14'd0, sel_len};
    dw1    = {REQ_ID, 8'(alloc_tag), (sel_len == 10'd1) ? 4'h0 : 4'hF, 4'hF};
    dw2    = is_4dw ? sel_addr[63:32] : {sel_addr[31:2], 2'b00};
    dw3    = is_4dw ? {sel_addr[31:2], 2'b00} : 32'h0;
    hdr_data        = '0;
    hdr_data[127:0] = {dw3, dw2, dw1, dw0};
    hdr_keep        = '0;
    hdr_keep[3:0]   = is_4dw ? 4'hF : 4'h7;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rr_q    <= 2'd0;
      tdata_q <= '0;
      tkeep_q <= '0;
      tag_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StSend;
            rr_q    <= rr_next;
            tdata_q <= hdr_data;
            tkeep_q <= hdr_keep;
            tag_q   <= {sel_dst, alloc_tag};
          end
        end
        StSend: begin
          if (m_axis_rx_tready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag is only taken from the pool on the handshake, so a reset mid-SEND loses nothing.
  always_comb begin
    rel_ok  = tag_free_vld && !free_q[tag_free];
    rel_dbl = tag_free_vld && free_q[tag_free];
    free_d  = free_q;
    if (handshake) free_d[tag_q[TAG_W-1:0]] = 1'b0;
    if (rel_ok)    free_d[tag_free] = 1'b1;
    outstanding_d = outstanding_q;
    if (handshake && !rel_ok)      outstanding_d = outstanding_q + 1'b1;
    else if (!handshake && rel_ok) outstanding_d = outstanding_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q        <= '1;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      free_q        <= free_d;
      outstanding_q <= outstanding_d;
      if (rel_dbl) err_q <= 1'b1;
    end
  end

  assign m_axis_rx_tvalid = (state_q == StSend);
  assign m_axis_rx_sop    = m_axis_rx_tvalid;
  assign m_axis_rx_eop    = m_axis_rx_tvalid;
  assign m_axis_rx_tdata  = tdata_q;
  assign m_axis_rx_tkeep  = tkeep_q;
  assign m_axis_rx_tuser  = '0;
  assign tag              = tag_q;
  assign tag_vld          = handshake;
  assign outstanding      = outstanding_q;
  assign err_dbl_free     = err_q;

  // Address bits [1:0] are DW-alignment slack and never reach the header.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s_rxsgl_addr[1:0], s_txsgl_addr[1:0], s_rxdat_addr[1:0],
                             sel_addr[1:0]};

endmodule

// File: doc/egress_rd_req_gen.md
# egress_rd_req_gen

Requester-side counterpart of the ingress completion parser. Accepts read requests from three internal clients (rx SGL fetch, tx SGL fetch, rx data fetch), allocates a free PCIe tag, emits one Memory Read TLP header per request on the egress AXIS stream, and publishes `{dst, tag}` so the ingress side can route the returning completions. Tags are returned to the pool when the ingress side reports the final completion for that tag.

## Interface
Parameters:
- `TAG_W`, 5: tag width; pool depth is 2^TAG_W (32).
- `DST_W`, 2: destination code width. Codes: 2'b00 rx SGL, 2'b01 tx SGL, 2'b11 rx data.
- `T_W`, `TAG_W+DST_W`: published tag word width, `{dst, tag}`.
- `REQ_ID`, 16'h0000: requester ID placed in header DW1[31:16].

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_rxsgl_addr` / `s_txsgl_addr` / `s_rxdat_addr`  in  64  byte address, DW aligned; bits [1:0] ignored.
- `s_rxsgl_len` / `s_txsgl_len` / `s_rxdat_len`  in  10  length in DW; 0 encodes 1024.
- `s_rxsgl_valid` / `s_txsgl_valid` / `s_rxdat_valid`  in  1  request valid.
- `s_rxsgl_rdy` / `s_txsgl_rdy` / `s_rxdat_rdy`  out  1  request accepted this cycle.
- `m_axis_rx_tready`  in  1  egress sink ready.
- `m_axis_rx_tdata`  out  `PCIE_DATA_WIDTH`  TLP header in DW0..DW3 (bits [127:0]); upper bits 0.
- `m_axis_rx_tkeep`  out  `PCIE_DATA_KW`  one bit per DW.
- `m_axis_rx_sop` / `m_axis_rx_eop`  out  1  both 1 whenever valid (single beat).
- `m_axis_rx_tvalid`  out  1.
- `m_axis_rx_tuser`  out  `PCIE_TUSER_W`  tied 0.
- `tag`  out  `T_W`  `{dst, tag}` of the issued request.
- `tag_vld`  out  1  one-cycle strobe.
- `tag_free`  in  `TAG_W`  tag to release.
- `tag_free_vld`  in  1  release strobe.
- `outstanding`  out  `TAG_W+1`  count of allocated tags.
- `err_dbl_free`  out  1  sticky: a free tag was released.

## Operation
- Free bitmap of 2^TAG_W bits; reset value all 1. Allocation uses the lowest-index free tag.
- FSM states IDLE and SEND.
  - IDLE: if any request valid and pool non-empty, round-robin grant over the order rx SGL → tx SGL → rx data. The pointer advances past the winner. Assert the winner's `*_rdy` combinationally in that cycle. Latch addr, len, dst and the allocated tag, then go to SEND. If the pool is empty, stay in IDLE with all `*_rdy`=0.
  - SEND: `tvalid`=1 with the header held stable. On `tvalid && tready`: clear the bitmap bit, pulse `tag_vld` with the latched `{dst, tag}`, increment `outstanding`, go to IDLE.
- Header fields:
  - Format: 4DW (fmt 3'b001) if addr[63:32]≠0, else 3DW (fmt 3'b000). Type 5'b00000. TC, attr, TD, EP all 0. Length = len.
  - DW1 = `{REQ_ID, 8'(tag), last_BE, first_BE}`. first_BE = 4'hF. last_BE = 4'h0 if len==1, else 4'hF.
  - 4DW: DW2 = addr[63:32], DW3 = `{addr[31:2], 2'b00}`. 3DW: DW2 = `{addr[31:2], 2'b00}`, DW3 = 0.
  - tkeep: 4'hF for 4DW, 4'h7 for 3DW; upper bits 0.
- Release: on `tag_free_vld`, if the bit is clear, set it and decrement `outstanding`. If the bit is already set, ignore the release and set `err_dbl_free`.
- Simultaneous release and allocation in one cycle: both bitmap updates apply and `outstanding` is unchanged. A tag released in cycle N is allocatable from cycle N+1.

## Timing
- Reset values: `tvalid`, `sop`, `eop`, `tag_vld`, all `*_rdy`, `err_dbl_free` = 0. `outstanding` = 0. `tdata`, `tkeep`, `tag` = 0. FSM = IDLE. Round-robin pointer = rx SGL.
- Request accept (cycle N) → `tvalid` in cycle N+1. Minimum issue interval is 2 cycles.
- `tag_vld` is asserted in the same cycle as the output handshake, so ingress registers the tag before any completion can return.
- Back-pressure: in SEND, tdata/tkeep are held and no new request is accepted.
- An asynchronous reset mid-SEND drops the TLP and restores the full pool.

## Test plan
- Single rx data read, addr 64'h0000_0000_1000_0040, len 16 → 3DW header: DW0=32'h0000_0010, DW1 = `{REQ_ID, 8'h00, 4'hF, 4'hF}`, DW2=32'h1000_0040, tkeep=3'h7. `tag` = 7'b11_00000 with `tag_vld` on the handshake. `outstanding`=1.
- Addr 64'h1_0000_0000, len 1, tx SGL → fmt 3'b001, last_BE=0, DW2=1, DW3=0, tkeep=4'hF, `tag` dst=2'b01.
- All three channels valid continuously, no frees → grants rxSGL, txSGL, rxdat repeating. Tags 0..31 are issued in order, then all `*_rdy` stay 0 and `outstanding`=32.
- With the pool full, free tag 7 → next request uses tag 7 one cycle later. `outstanding` 32→31→32.
- tready held low for 5 cycles in SEND → header stable, single `tag_vld` on release, no extra accepts.
- Free tag 3 while it is unallocated → `err_dbl_free`=1 (sticky), `outstanding` unchanged. Simultaneous free of tag 0 with allocation of tag 1 → `outstanding` unchanged.
